// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Divisors are expressed in clk50 cycles (50 MHz reference).
package tick_gen_pkg;

  localparam int unsigned CLK_HZ          = 50_000_000;
  localparam int          CNT_W_DEF       = 20;
  localparam int          DEFAULT_DIV_DEF = 516_666;

  // Divisor for a target tick rate, rounded to the nearest whole cycle.
  function automatic int unsigned hz_to_div(input int unsigned hz);
    if (hz == 0) return 0;
    return (CLK_HZ + hz / 2) / hz;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rate of the old fixed single-channel divider (208_333).
  localparam int unsigned LEGACY_240HZ_DIV = hz_to_div(240);

endpackage

// File: rtl/tick_gen_multi_if.sv
// Host-side control/status bundle of tick_gen_multi.
// Optional square-wave outputs appear when TICKGEN_SQUARE_EN is defined.
interface tick_gen_multi_if
  import tick_gen_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int CH_W = ch_width(NCH);

  logic [NCH-1:0]       ch_en;
  logic                 sync_clr;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [CNT_W-1:0]     cfg_div;
  logic [NCH-1:0]       tick;
  logic [NCH*CNT_W-1:0] div_rd;
`ifdef TICKGEN_SQUARE_EN
  logic [NCH-1:0]       sq;
`endif

  modport master (
    output ch_en, sync_clr, cfg_we, cfg_ch, cfg_div,
`ifdef TICKGEN_SQUARE_EN
    input  sq,
`endif
    input  tick, div_rd
  );

  modport slave (
    input  ch_en, sync_clr, cfg_we, cfg_ch, cfg_div,
`ifdef TICKGEN_SQUARE_EN
    output sq,
`endif
    output tick, div_rd
  );

endinterface

// File: rtl/tick_gen_channel.sv
// One tick channel: counter, shadow/active divisor pair and registered tick.
// With TICKGEN_SQUARE_EN a toggle flop produces a square wave of period 2*active.
module tick_gen_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk50,
  input  logic             nreset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
`ifdef TICKGEN_SQUARE_EN
  output logic             sq,
`endif
  output logic [CNT_W-1:0] active
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic             tick_q, tick_d;

  // The wrap edge loads the shadow value captured before this cycle's write,
  // so a write landing on a wrap takes effect one period later.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    tick_d   = 1'b0;
    if (wr) shadow_d = wr_div;
    if (sync_clr) begin
      cnt_d    = '0;
      active_d = wr ? wr_div : shadow_q;
    end else if (!en || active_q == '0) begin
      cnt_d    = '0;
      active_d = shadow_q;
    end else if (cnt_q == active_q - CNT_W'(1)) begin
      cnt_d    = '0;
      tick_d   = 1'b1;
      active_d = shadow_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk50 or negedge nreset) begin
    if (!nreset) begin
      cnt_q    <= '0;
      shadow_q <= CNT_W'(DEFAULT_DIV);
      active_q <= CNT_W'(DEFAULT_DIV);
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      tick_q   <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign active = active_q;

`ifdef TICKGEN_SQUARE_EN
  logic sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    if (sync_clr || !en) sq_d = 1'b0;
    else if (tick_d)     sq_d = ~sq_q;
  end

  always_ff @(posedge clk50 or negedge nreset) begin
    if (!nreset) sq_q <= 1'b0;
    else         sq_q <= sq_d;
  end

  assign sq = sq_q;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: write decode plus one channel per tick.
// TICKGEN_SQUARE_EN adds a per-channel square-wave output on the bus.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic            clk50,
  input  logic            nreset,
  tick_gen_multi_if.slave bus
);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic wr;

      // Channel numbers at or above NCH match no instance, so such writes drop.
      assign wr = bus.cfg_we && (32'(bus.cfg_ch) == gi);

      tick_gen_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk50    (clk50),
        .nreset   (nreset),
        .en       (bus.ch_en[gi]),
        .sync_clr (bus.sync_clr),
        .wr       (wr),
        .wr_div   (bus.cfg_div),
        .tick     (bus.tick[gi]),
`ifdef TICKGEN_SQUARE_EN
        .sq       (bus.sq[gi]),
`endif
        .active   (bus.div_rd[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed scenarios plus random traffic against a
// timestamp-based reference model (next tick time per channel).
module tb_tick_gen_multi;
  import tick_gen_pkg::*;

  localparam int NCH     = 4;
  localparam int CNT_W   = 20;
  localparam int DEF_DIV = 4;
  localparam int CH_W    = ch_width(NCH);

  logic clk50  = 1'b0;
  logic nreset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  tick_gen_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus();

  tick_gen_multi #(
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk50  (clk50),
    .nreset (nreset),
    .bus    (bus)
  );

  always #10 clk50 = ~clk50;

  // Reference model: per channel the absolute edge number of its next tick.
  int unsigned    m_active [NCH];
  int unsigned    m_shadow [NCH];
  longint         m_next   [NCH];
  longint         cyc;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_tick = '0;
    m_sq   = '0;
    for (int i = 0; i < NCH; i++) begin
      m_active[i] = DEF_DIV;
      m_shadow[i] = DEF_DIV;
      m_next[i]   = DEF_DIV;
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      bit          w;
      int unsigned old_sh;
      w         = bus.cfg_we && (int'(bus.cfg_ch) == i);
      old_sh    = m_shadow[i];
      m_tick[i] = 1'b0;
      if (w) m_shadow[i] = bus.cfg_div;
      if (bus.sync_clr) begin
        m_active[i] = w ? int'(bus.cfg_div) : old_sh;
        m_next[i]   = cyc + m_active[i];
        m_sq[i]     = 1'b0;
      end else if (!bus.ch_en[i] || m_active[i] == 0) begin
        if (!bus.ch_en[i]) m_sq[i] = 1'b0;
        m_active[i] = old_sh;
        m_next[i]   = cyc + m_active[i];
      end else if (cyc == m_next[i]) begin
        m_tick[i]   = 1'b1;
        m_sq[i]     = ~m_sq[i];
        m_active[i] = old_sh;
        m_next[i]   = cyc + m_active[i];
      end
    end
  endtask

  function automatic logic [NCH*CNT_W-1:0] exp_div();
    logic [NCH*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_active[i]);
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "/tick"}, 128'(bus.tick), 128'(m_tick));
    check_val({tag, "/div_rd"}, 128'(bus.div_rd), 128'(exp_div()));
`ifdef TICKGEN_SQUARE_EN
    check_val({tag, "/sq"}, 128'(bus.sq), 128'(m_sq));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk50);
    model_edge();
    #1;
    check_outputs(tag);
    bus.cfg_we   = 1'b0;
    bus.sync_clr = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int unsigned div, input bit sclr);
    logic [31:0] ch_v;
    ch_v         = ch;
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = ch_v[CH_W-1:0];
    bus.cfg_div  = CNT_W'(div);
    bus.sync_clr = sclr;
    $display("[TB] cfg write ch=%0d div=%0d sync_clr=%0d at edge %0d", ch, div, sclr, cyc + 1);
    cycle("cfg");
  endtask

  initial begin
    int          j;
    int          r;
    int unsigned d;

    bus.ch_en    = '0;
    bus.sync_clr = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_div  = '0;
    model_reset();
    #25;
    check_outputs("reset");

    bus.ch_en = '1;
    @(negedge clk50);
    nreset = 1'b1;
    repeat (13) cycle("base");

    // ch1 counter is 1 here: current period stays 4, then 6.
    cfg_write(1, 6, 1'b0);
    repeat (30) cycle("div6");

    cfg_write(2, 1, 1'b1);
    repeat (10) cycle("div1");
    cfg_write(2, 0, 1'b1);
    repeat (100) cycle("div0");

    repeat (2) cycle("pre_off");
    bus.ch_en[3] = 1'b0;
    repeat (5) cycle("en_off");
    bus.ch_en[3] = 1'b1;
    repeat (10) cycle("en_on");

    cfg_write(0, hz_to_div(16_666_667), 1'b0);
    cfg_write(1, hz_to_div(10_000_000), 1'b1);
    repeat (20) cycle("align");
    cfg_write(2, 4, 1'b0);
    repeat (8) cycle("restart");

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        j = int'($urandom_range(0, NCH - 1));
        bus.ch_en[j] = ~bus.ch_en[j];
      end
      if ($urandom_range(0, 7) == 0) begin
        d = $urandom_range(1, 9);
        r = int'($urandom_range(0, 29));
        if (r == 0)      d = 0;
        else if (r == 1) d = LEGACY_240HZ_DIV;
        cfg_write(int'($urandom_range(0, NCH - 1)), d, $urandom_range(0, 9) == 0);
      end else begin
        bus.sync_clr = ($urandom_range(0, 49) == 0);
        cycle("rand");
      end
    end

    // Asynchronous reset in the middle of counting, with ch2 ticking constantly.
    bus.ch_en = '1;
    cfg_write(2, 1, 1'b1);
    repeat (3) cycle("pre_rst");
    #3;
    nreset = 1'b0;
    #2;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk50);
    nreset = 1'b1;
    repeat (12) cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_gen_multi.md
Name: tick_gen_multi

Overview:
- Multi-channel programmable tick generator on clk50. Successor to the fixed single-channel 240 Hz divider.
- Each of NCH channels emits a one-cycle pulse every div[i] clk50 cycles.
- Divisors are runtime-loadable through a simple write port, with glitch-free update at terminal count.
- Feeds display refresh, debounce and scan logic in topIO with independent rates from one block.

Parameters:
- NCH, 4, number of independent tick channels (1..16).
- CNT_W, 20, counter/divisor width in bits.
- DEFAULT_DIV, 516_666, divisor loaded into every channel at reset.

Ports:
- clk50  input  1  system clock, 50 MHz.
- nreset  input  1  asynchronous reset, active-low.
- ch_en  input  NCH  per-channel enable, level.
- sync_clr  input  1  synchronous phase-align pulse, all channels.
- cfg_we  input  1  divisor write strobe, one cycle.
- cfg_ch  input  $clog2(NCH) (min 1)  target channel of write.
- cfg_div  input  CNT_W  new divisor value.
- tick  output  NCH  one-cycle pulse per channel, registered.
- div_rd  output  NCH*CNT_W  active divisor of each channel, channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (asynchronous, nreset=0), per channel:
  - counter=0; shadow=active=DEFAULT_DIV; tick=0.
  - div_rd reflects DEFAULT_DIV.
- Counting, per channel with ch_en[i]=1 and active>=1:
  - counter runs 0..active-1, then wraps to 0.
  - On the edge where counter==active-1: counter<=0, tick[i]<=1. On every other edge tick[i]<=0.
  - Tick period is exactly active cycles, width exactly 1 cycle.
  - Example: DIV=4, en high from reset release → tick high in cycles 4, 8, 12, ... (cycles counted from the first edge after release as cycle 1).
- active==1: tick[i] held high continuously while enabled; counter stays 0.
- active==0: channel halted; counter held 0, tick 0. Only a write with nonzero divisor plus sync_clr, or a wrap-free load (see below), restarts it.
- ch_en[i]=0: counter forced to 0 and tick[i]=0 on next edge. On re-enable, counting restarts from 0, so the first tick comes active cycles later.
- Divisor write (cfg_we=1, cfg_ch<NCH):
  - cfg_div is stored in shadow[cfg_ch].
  - shadow is copied to active at the next wrap edge (counter==active-1) of that channel. The wrap that copies uses the old divisor, so no truncated or stretched period occurs.
  - If the channel is disabled or active==0, shadow is copied to active on the next edge.
  - cfg_ch>=NCH: write ignored.
- sync_clr=1: all counters<=0 and tick<=0; every shadow copied to active immediately. All enabled channels are phase-aligned from the next cycle.
- sync_clr and cfg_we in the same cycle: cfg_div goes to both shadow and active of cfg_ch (write wins).
- Wrap and cfg_we on the same channel in the same cycle:
  - The wrap loads the old shadow.
  - The new value lands in shadow and takes effect at the following wrap.
- Arithmetic:
  - Counter increment is CNT_W-bit unsigned; the compare is the only wrap mechanism.
  - cfg_div is used unmodified (no off-by-one adjustment by the host).
- Reset asserted mid-count: immediate return to reset state; in-flight shadow values are lost.

Optional Feature:
- Macro: TICKGEN_SQUARE_EN.
- When defined:
  - Adds output sq [NCH], a registered per-channel 50%-class square wave.
  - sq[i] toggles on every tick edge, so its period is 2*active.
  - Reset, sync_clr or ch_en[i]=0 force sq[i]=0.
  - With active==1, sq[i] toggles every cycle (25 MHz).
- When undefined: port sq is absent and no toggle flops are synthesized. All other behaviour is identical.

Decomposition:
- Package tick_gen_pkg:
  - CNT_W and DEFAULT_DIV defaults.
  - Constant for the 240 Hz legacy divisor (208_333).
  - Function computing divisor from target Hz at 50 MHz, used by testbench and top-level constants.
- Sub-module tick_gen_channel, one instance per channel via generate:
  - Owns counter, shadow, active, tick and optional sq.
  - Inputs: en, sync_clr, wr, wr_div.
- Top level tick_gen_multi contains cfg decode, instances and div_rd packing only.

Test Plan:
- Reset release, NCH=4, DEFAULT_DIV=4, all enabled → each tick high in cycles 4, 8, 12; div_rd=4 for all channels.
- Write cfg_ch=1, cfg_div=6 when ch1 counter=1 → current period stays 4; following periods are 6; other channels unaffected.
- Set div=1 then div=0 on ch2 with sync_clr:
  - div=1 → tick[2] constant high.
  - div=0 → tick[2] stays 0 for 100 cycles.
- Drop ch_en[3] mid-count (counter=2) for 5 cycles, then re-enable → no tick while low; first tick exactly 4 cycles after re-enable.
- Channels with divisors 3 and 5, pulse sync_clr → both counters 0 next cycle; ticks coincide at cycle 15 after sync_clr.
- With TICKGEN_SQUARE_EN and div=4 → sq toggles at each tick (period 8). nreset pulsed mid-count → all outputs 0 asynchronously and divisors return to DEFAULT_DIV.
